// File: rtl/uart_tx_fifo.sv
// UART transmitter draining a show-ahead FIFO: one pop per frame, 8 data bits
// LSB first, optional odd/even parity, 1 or 2 stop bits, idle-high line.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end

  localparam int              CNT_W      = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam bit              HAS_PARITY = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic             stop_idx;
  logic [7:0]       data_q;

  logic fetch_ok;
  logic bit_done;
  logic parity_bit;
  logic last_stop;

  assign fetch_ok   = enable && !fifo_empty;
  assign bit_done   = (baud_cnt == CNT_LAST);
  assign parity_bit = (PARITY == 1) ? ~^data_q : ^data_q;
  assign last_stop  = (STOP_BITS == 2) ? stop_idx : 1'b1;

  // NOTE: every register here uses <= so all next-state terms read the pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      data_q   <= '0;
      fifo_rd  <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      // NOTE: fifo_rd defaults low each cycle so a fetch yields a one-cycle strobe.
      fifo_rd <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fetch_ok) begin
            data_q   <= fifo_data;
            fifo_rd  <= 1'b1;
            tx       <= 1'b0;
            busy     <= 1'b1;
            baud_cnt <= '0;
            state    <= S_START;
          end
        end

        S_START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= data_q[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              stop_idx <= 1'b0;
              if (HAS_PARITY) begin
                tx    <= parity_bit;
                state <= S_PARITY;
              end else begin
                tx    <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= data_q[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        S_PARITY: begin
          if (bit_done) begin
            baud_cnt <= '0;
            stop_idx <= 1'b0;
            tx       <= 1'b1;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (!last_stop) begin
              stop_idx <= 1'b1;
            end else if (fetch_ok) begin
              // Back-to-back: the next start bit follows the last stop cycle directly.
              data_q  <= fifo_data;
              fifo_rd <= 1'b1;
              tx      <= 1'b0;
              state   <= S_START;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: dut_a is 4 clk/bit even parity 1 stop,
// dut_b is 4 clk/bit odd parity 2 stop; each is fed by its own 16-deep FIFO model.
module tb_uart_tx_fifo;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [1:0] fifo_empty;
  logic [1:0] fifo_rd;
  logic [1:0] tx;
  logic [1:0] busy;
  logic [7:0] fifo_data [2];

  logic [7:0] mem [2][16];
  logic [4:0] wp [2] = '{5'd0, 5'd0};
  logic [4:0] rp [2] = '{5'd0, 5'd0};
  logic [1:0] wr_en;
  logic [7:0] wr_data;
  int         pops [2] = '{0, 0};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .fifo_data(fifo_data[0]), .fifo_empty(fifo_empty[0]),
    .fifo_rd(fifo_rd[0]), .tx(tx[0]), .busy(busy[0])
  );

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .fifo_data(fifo_data[1]), .fifo_empty(fifo_empty[1]),
    .fifo_rd(fifo_rd[1]), .tx(tx[1]), .busy(busy[1])
  );

  // Show-ahead FIFO models; they are not touched by the UART reset.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (wr_en[i]) begin
        mem[i][wp[i][3:0]] <= wr_data;
        wp[i] <= wp[i] + 5'd1;
      end
      if (fifo_rd[i] && !fifo_empty[i]) begin
        rp[i]   <= rp[i] + 5'd1;
        pops[i] <= pops[i] + 1;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    assign fifo_empty[g] = (wp[g] == rp[g]);
    assign fifo_data[g]  = mem[g][rp[g][3:0]];
  end

  task automatic push(input int sel, input logic [7:0] value);
    wr_en[sel] = 1'b1;
    wr_data    = value;
    @(negedge clk);
    wr_en[sel] = 1'b0;
  endtask

  // Returns negedges until tx falls, or -1 if it never does within the budget.
  task automatic wait_fall(input int sel, output int lat);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (tx[sel] === 1'b0) begin
        lat = n;
        break;
      end
    end
  endtask

  // Entered on the first start-bit negedge; samples mid-bit, returns at the frame end.
  task automatic decode_frame(input int sel, input int nbits, output logic [11:0] bits);
    bits = '1;
    for (int k = 0; k < nbits; k++) begin
      repeat (CPB / 2) @(negedge clk);
      bits[k] = tx[sel];
      repeat (CPB - CPB / 2) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (tx !== 2'b11 || busy !== 2'b00 || fifo_rd !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: tx=%b busy=%b fifo_rd=%b, expected tx=11 busy=00 fifo_rd=00",
               tx, busy, fifo_rd);
    end
    reset_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      checks++;
      if (tx !== 2'b11 || busy !== 2'b00 || fifo_rd !== 2'b00) begin
        errors++;
        $display("FAIL idle_empty cycle %0d: tx=%b busy=%b fifo_rd=%b, expected 11/00/00",
                 c, tx, busy, fifo_rd);
      end
    end
  endtask

  task automatic test_single_byte();
    logic [10:0] exp_frame;
    int          lat;
    int          p0;
    exp_frame = 11'b1_0_10100101_0;
    p0 = pops[0];
    push(0, 8'hA5);
    wait_fall(0, lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL single_start_latency: got %0d negedges, expected 1", lat);
    end
    for (int c = 0; c < 11 * CPB; c++) begin
      checks++;
      if (tx[0] !== exp_frame[c / CPB] || busy[0] !== 1'b1 || fifo_rd[0] !== (c == 0)) begin
        errors++;
        $display("FAIL single_frame cycle %0d: tx=%b busy=%b fifo_rd=%b, expected tx=%b busy=1 fifo_rd=%b",
                 c, tx[0], busy[0], fifo_rd[0], exp_frame[c / CPB], (c == 0));
      end
      @(negedge clk);
    end
    checks++;
    if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || fifo_empty[0] !== 1'b1 || pops[0] - p0 !== 1) begin
      errors++;
      $display("FAIL single_end: tx=%b busy=%b empty=%b pops=%0d, expected 1/0/1/1",
               tx[0], busy[0], fifo_empty[0], pops[0] - p0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  exp_b [3];
    logic [11:0] bits;
    logic        exp_tx;
    int          lat;
    int          p0;
    exp_b = '{8'h00, 8'hFF, 8'h55};
    p0 = pops[0];
    enable = 1'b0;
    push(0, 8'h00);
    push(0, 8'hFF);
    push(0, 8'h55);
    enable = 1'b1;
    wait_fall(0, lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL b2b_start_latency: got %0d negedges, expected 1", lat);
    end
    for (int i = 0; i < 3; i++) begin
      exp_tx = (i < 2) ? 1'b0 : 1'b1;
      decode_frame(0, 11, bits);
      checks++;
      if (bits[10:0] !== {1'b1, 1'b0, exp_b[i], 1'b0}) begin
        errors++;
        $display("FAIL b2b_frame %0d: got %b, expected %b", i, bits[10:0],
                 {1'b1, 1'b0, exp_b[i], 1'b0});
      end
      checks++;
      if (tx[0] !== exp_tx) begin
        errors++;
        $display("FAIL b2b_spacing %0d: tx=%b 44 clk after start, expected %b", i, tx[0], exp_tx);
      end
    end
    checks++;
    if (busy[0] !== 1'b0 || fifo_empty[0] !== 1'b1 || pops[0] - p0 !== 3) begin
      errors++;
      $display("FAIL b2b_end: busy=%b empty=%b pops=%0d, expected 0/1/3",
               busy[0], fifo_empty[0], pops[0] - p0);
    end
  endtask

  task automatic test_parity_stop();
    logic [11:0] exp_frame;
    int          lat;
    exp_frame = 12'b11_1_00000000_0;
    push(1, 8'h00);
    wait_fall(1, lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL odd2_start_latency: got %0d negedges, expected 1", lat);
    end
    for (int c = 0; c < 12 * CPB; c++) begin
      checks++;
      if (tx[1] !== exp_frame[c / CPB] || busy[1] !== 1'b1 || fifo_rd[1] !== (c == 0)) begin
        errors++;
        $display("FAIL odd2_frame cycle %0d: tx=%b busy=%b fifo_rd=%b, expected tx=%b busy=1 fifo_rd=%b",
                 c, tx[1], busy[1], fifo_rd[1], exp_frame[c / CPB], (c == 0));
      end
      @(negedge clk);
    end
    checks++;
    if (tx[1] !== 1'b1 || busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL odd2_end: tx=%b busy=%b after 48 clk, expected 1/0", tx[1], busy[1]);
    end
  endtask

  task automatic test_enable_gate();
    logic [11:0] bits;
    int          lat;
    int          p0;
    p0 = pops[0];
    enable = 1'b0;
    push(0, 8'h3C);
    push(0, 8'hC3);
    enable = 1'b1;
    wait_fall(0, lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL gate_start_latency: got %0d negedges, expected 1", lat);
    end
    repeat (13) @(negedge clk);
    enable = 1'b0;
    repeat (11 * CPB - 13) @(negedge clk);
    checks++;
    if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || pops[0] - p0 !== 1) begin
      errors++;
      $display("FAIL gate_frame1_end: tx=%b busy=%b pops=%0d, expected 1/0/1",
               tx[0], busy[0], pops[0] - p0);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (tx[0] !== 1'b1 || fifo_rd[0] !== 1'b0 || busy[0] !== 1'b0) begin
        errors++;
        $display("FAIL gate_hold cycle %0d: tx=%b fifo_rd=%b busy=%b, expected 1/0/0",
                 c, tx[0], fifo_rd[0], busy[0]);
      end
    end
    checks++;
    if (fifo_empty[0] !== 1'b0) begin
      errors++;
      $display("FAIL gate_queued: empty=%b, expected 0", fifo_empty[0]);
    end
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if (tx[0] !== 1'b0 || fifo_rd[0] !== 1'b1) begin
      errors++;
      $display("FAIL gate_resume: tx=%b fifo_rd=%b one clk after enable, expected 0/1",
               tx[0], fifo_rd[0]);
    end
    decode_frame(0, 11, bits);
    checks++;
    if (bits[10:0] !== 11'b1_0_11000011_0) begin
      errors++;
      $display("FAIL gate_frame2: got %b, expected %b", bits[10:0], 11'b1_0_11000011_0);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [11:0] bits;
    int          lat;
    int          p0;
    p0 = pops[0];
    enable = 1'b0;
    push(0, 8'h81);
    push(0, 8'h7E);
    enable = 1'b1;
    wait_fall(0, lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL abort_start_latency: got %0d negedges, expected 1", lat);
    end
    repeat (17) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || fifo_rd[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_async: tx=%b busy=%b fifo_rd=%b right after reset, expected 1/0/0",
               tx[0], busy[0], fifo_rd[0]);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_fall(0, lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL abort_restart_latency: got %0d negedges, expected 1", lat);
    end
    decode_frame(0, 11, bits);
    checks++;
    if (bits[10:0] !== 11'b1_0_01111110_0) begin
      errors++;
      $display("FAIL abort_next_frame: got %b, expected %b", bits[10:0], 11'b1_0_01111110_0);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || fifo_empty[0] !== 1'b1 || pops[0] - p0 !== 2) begin
      errors++;
      $display("FAIL abort_end: tx=%b busy=%b empty=%b pops=%0d, expected 1/0/1/2",
               tx[0], busy[0], fifo_empty[0], pops[0] - p0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    enable  = 1'b1;
    wr_en   = 2'b00;
    wr_data = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_parity_stop();
    test_enable_gate();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
